ram_port1_arbiter: RTL
======================

// Module: ram_port1_arbiter
//
// PURPOSE
// - Shares write/read port 1 of the dual-port half-word RAM between two 32-bit masters.
//   - m0 is the CPU data bus.
//   - m1 is the loader/DMA.
// - Each word access is split into two half-word beats (low half, then high half).
// - Fair round-robin arbitration; req/ack handshake toward each master.
// - Port 2 (instruction fetch) is untouched and connects directly to the RAM.
//
// PARAMETERS
// - ADDR_WIDTH  12  byte-address width; matches the RAM ADDR_WIDTH.
//
// PORTS
// - clk          in   1           system clock; all state updates on rising edge
// - rst          in   1           synchronous, active-high reset
// - m0_req       in   1           m0 access request; held high until m0_ack
// - m0_addr      in   ADDR_WIDTH  m0 byte address; bits [1:0] ignored (word-aligned)
// - m0_wdata     in   32          m0 write data
// - m0_wstrb     in   4           m0 byte write enables; 4'b0000 = read
// - m0_ack       out  1           one-cycle completion pulse to m0
// - m0_rdata     out  32          m0 read data; valid while m0_ack=1
// - m1_*         same set as m0_* for master 1
// - ram_addr     out  ADDR_WIDTH  to RAM addr_1
// - ram_wdata    out  16          to RAM wdata_1
// - ram_wenable  out  2           to RAM wenable_1
// - ram_rdata    in   16          from RAM rdata_1 (combinational read)
//
// BEHAVIOUR
// - Reset values: m*_ack=0, m*_rdata=0, ram_wenable=0, ram_addr=0, ram_wdata=0.
//   - FSM goes to IDLE; last_grant=1, so m0 wins the first tie.
// - FSM states and transitions:
//   - IDLE -> LO: when any req=1. Grant is latched into owner; addr/wdata/wstrb are
//     latched from the granted master.
//   - LO -> HI -> ACK -> IDLE: unconditional, one cycle each.
// - Arbitration in IDLE:
//   - Single requester wins.
//   - If both request, grant goes to ~last_grant.
//   - last_grant <= owner on each IDLE->LO transition.
// - Beat outputs (only in LO and HI):
//   - LO: ram_addr={a[AW-1:2],2'b00}; ram_wdata=wdata[15:0]; ram_wenable=wstrb[1:0].
//   - HI: ram_addr={a[AW-1:2],2'b10}; ram_wdata=wdata[31:16]; ram_wenable=wstrb[3:2].
//   - In IDLE and ACK, ram_wenable=0 and ram_addr holds its last value.
// - Read capture:
//   - rbuf[15:0]<=ram_rdata at the end of LO.
//   - rbuf[31:16]<=ram_rdata at the end of HI.
//   - Capture happens even on writes, so a write returns post-write data for untouched
//     bytes only; masters ignore rdata on writes.
// - Ack:
//   - In ACK, m<owner>_ack=1 and m<owner>_rdata=rbuf.
//   - The other master's ack stays 0; its rdata holds its previous value.
// - Latency: req seen in IDLE at cycle 0 -> LO at 1 -> HI at 2 -> ack high at 3.
//   - Throughput: one word per 4 cycles.
// - Req held high through the ACK cycle counts as a new request in the following IDLE.
//   It is subject to round-robin, so the other master wins if it is requesting.
// - Req dropped before ack (protocol violation): the transaction still completes and
//   ack still pulses.
// - Reset mid-transaction:
//   - Abort to IDLE with no ack.
//   - A LO beat already written stays written (partial word write is permitted).
//   - ram_wenable=0 from the cycle after the reset edge.
// - Width rule: wstrb bits map 1:1 to bytes; wstrb=4'b0011 writes only the low half-word.
//
// STRUCTURE
// - Shared header mem_defs.vh (included by this block and the RAM top):
//   - FSM state localparams: IDLE=2'd0, LO=2'd1, HI=2'd2, ACK=2'd3.
//   - Half-word offset constants: HW_LO=2'b00, HW_HI=2'b10.
//   - Bus widths: WORD_W=32, HWORD_W=16.
// - One sub-module, rr_arbiter2.
//   - Inputs: clk, rst, req[1:0], advance.
//   - Outputs: grant_idx, grant_valid.
//   - Holds last_grant.
// - The beat sequencer and muxing stay in this module.
//
// TESTING
// - Reset, then m0 writes 0xDEADBEEF @0x010 with wstrb=F.
//   - RAM hw[8]=0xBEEF and hw[9]=0xDEAD.
//   - m0_ack high at cycle 3 only.
// - m0 reads @0x010 after that write.
//   - m0_rdata=0xDEADBEEF while ack is high; m1_ack stays 0.
// - m0 and m1 request in the same cycle, both holding req.
//   - Grants alternate m0, m1, m0, m1; acks 4 cycles apart.
// - m1 writes 0x11223344 @0x020 with wstrb=4'b0100.
//   - Only byte 0x022 changes, to 0x22; ram_wenable goes 2'b00 (LO) then 2'b01 (HI).
// - Assert rst during the HI of an m0 write 0xAAAA5555 @0x030 (init 0).
//   - No ack; hw[0x18]=0x5555, hw[0x19]=0x0000.
//   - Next request from m1 is served first (last_grant=1 is re-established by reset).

Source files
------------

// File: rtl/ram_port1_arbiter_pkg.sv
// Shared definitions for the port-1 half-word RAM arbiter: beat FSM states,
// half-word offsets within a word and bus widths.
package ram_port1_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

  localparam logic [1:0] HW_LO = 2'b00;
  localparam logic [1:0] HW_HI = 2'b10;

  localparam int WORD_W  = 32;
  localparam int HWORD_W = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The grant is combinational from req and the
// remembered last winner; last_grant only moves when the caller advances.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant_idx,
  output logic       grant_valid
);

  logic last_grant_q;

  // Lone requester wins; on a tie the master that did not win last time goes.
  always_comb begin
    grant_valid = |req;
    if (req == 2'b11) begin
      grant_idx = ~last_grant_q;
    end else begin
      grant_idx = req[1];
    end
  end

  // Remember the winner; reset to 1 so master 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (advance && grant_valid) begin
      last_grant_q <= grant_idx;
    end
  end

endmodule

// File: rtl/ram_port1_arbiter.sv
// Shares RAM port 1 between two 32-bit masters. Each word access is run as a
// low half-word beat followed by a high half-word beat, then a one-cycle ack.
module ram_port1_arbiter
  import ram_port1_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [WORD_W-1:0]     m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic                  m0_ack,
  output logic [WORD_W-1:0]     m0_rdata,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [WORD_W-1:0]     m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic                  m1_ack,
  output logic [WORD_W-1:0]     m1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [HWORD_W-1:0]    ram_wdata,
  output logic [1:0]            ram_wenable,
  input  logic [HWORD_W-1:0]    ram_rdata
);

  state_e                  state_q;
  logic                    owner_q;
  logic [ADDR_WIDTH-1:2]   addr_q;
  logic [WORD_W-1:0]       wdata_q;
  logic [3:0]              wstrb_q;
  logic [HWORD_W-1:0]      rbuf_lo_q;
  logic [ADDR_WIDTH-1:0]   ram_addr_q;
  logic [HWORD_W-1:0]      ram_wdata_q;
  logic [1:0]              ram_wenable_q;
  logic                    m0_ack_q;
  logic                    m1_ack_q;
  logic [WORD_W-1:0]       m0_rdata_q;
  logic [WORD_W-1:0]       m1_rdata_q;

  logic                    grant_idx;
  logic                    grant_valid;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [WORD_W-1:0]       sel_wdata;
  logic [3:0]              sel_wstrb;

  // Byte-offset bits are ignored: every access is word aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[1:0], m1_addr[1:0], sel_addr[1:0]};

  rr_arbiter2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         ({m1_req, m0_req}),
    .advance     (state_q == ST_IDLE),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Steer the granted master's request fields toward the latch in IDLE.
  always_comb begin
    sel_addr  = grant_idx ? m1_addr  : m0_addr;
    sel_wdata = grant_idx ? m1_wdata : m0_wdata;
    sel_wstrb = grant_idx ? m1_wstrb : m0_wstrb;
  end

  // Beat sequencer: IDLE -> LO -> HI -> ACK, all RAM and master outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rbuf_lo_q     <= '0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      ram_wenable_q <= '0;
      m0_ack_q      <= 1'b0;
      m1_ack_q      <= 1'b0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ram_wenable_q <= '0;
          if (grant_valid) begin
            owner_q       <= grant_idx;
            addr_q        <= sel_addr[ADDR_WIDTH-1:2];
            wdata_q       <= sel_wdata;
            wstrb_q       <= sel_wstrb;
            ram_addr_q    <= {sel_addr[ADDR_WIDTH-1:2], HW_LO};
            ram_wdata_q   <= sel_wdata[HWORD_W-1:0];
            ram_wenable_q <= sel_wstrb[1:0];
            state_q       <= ST_LO;
          end
        end
        ST_LO: begin
          rbuf_lo_q     <= ram_rdata;
          ram_addr_q    <= {addr_q, HW_HI};
          ram_wdata_q   <= wdata_q[WORD_W-1:HWORD_W];
          ram_wenable_q <= wstrb_q[3:2];
          state_q       <= ST_HI;
        end
        ST_HI: begin
          // The high half goes straight into the returned word.
          ram_wenable_q <= '0;
          if (owner_q) begin
            m1_ack_q   <= 1'b1;
            m1_rdata_q <= {ram_rdata, rbuf_lo_q};
          end else begin
            m0_ack_q   <= 1'b1;
            m0_rdata_q <= {ram_rdata, rbuf_lo_q};
          end
          state_q <= ST_ACK;
        end
        ST_ACK: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // A reset arriving during a beat also suppresses that beat's write, so an
  // aborted word keeps only the beats written before the reset cycle.
  assign ram_wenable = ram_wenable_q & ~{2{rst}};
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign m0_ack      = m0_ack_q;
  assign m1_ack      = m1_ack_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;

endmodule
